// File: rtl/mac8_ctrl_pkg.sv
// Shared types and width helpers for the MAC8 dot-product scheduler.
package mac8_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_SETTLE,
    ST_DONE
  } state_t;

  // The accumulator must hold 2^len_w products of 8x8 bits without overflow.
  function automatic int unsigned calc_res_w(input int unsigned len_w);
    return 16 + len_w;
  endfunction

endpackage

// File: rtl/mac8_dot_sched_rr_arb2.sv
// Two-way round-robin arbiter: on contention the requester not served last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       en,
  output logic [1:0] gnt
);

  // One-hot grant selection; last=1 means requester 1 was served last.
  always_comb begin
    gnt = '0;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last ? 2'b01 : 2'b10;
        default: gnt = '0;
      endcase
    end
  end

endmodule

// File: rtl/mac8_dot_sched.sv
// Scheduler that runs dot-product jobs from two requesters through an
// external MAC8 datapath, with per-job length, stall timeout and result hold.
module mac8_dot_sched
  import mac8_ctrl_pkg::*;
#(
  parameter  int unsigned LEN_W  = 4,
  parameter  int unsigned TO_CYC = 255,
  localparam int unsigned RES_W  = calc_res_w(LEN_W)
) (
  input  logic             SYS_CLK,
  input  logic             SYS_RST,
  input  logic [1:0]       start,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  output logic [1:0]       gnt,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       mac_a,
  output logic [7:0]       mac_b,
  output logic             mac_en,
  output logic             mac_clr,
  input  logic [RES_W-1:0] mac_acc,
  output logic [RES_W-1:0] res,
  output logic             res_id,
  output logic             res_err,
  output logic             res_valid,
  input  logic             res_ready
);

  localparam int unsigned TO_W = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_gnt;
  logic             r_idx;
  logic             r_last;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;
  logic [TO_W-1:0]  r_idle;
  logic [RES_W-1:0] r_res;
  logic             r_res_id;
  logic             r_res_err;

  logic [1:0]       w_arb_gnt;
  logic             w_feed;
  logic             w_beat;
  logic             w_last_beat;
  logic             w_timeout;

  assign w_feed      = (r_state == ST_FEED);
  assign w_beat      = w_feed && in_valid;
  assign w_last_beat = w_beat && (r_cnt == r_len);
  assign w_timeout   = w_feed && !w_beat && (r_idle == TO_W'(TO_CYC - 1));

  rr_arb2 u_arb (
    .req  (start),
    .last (r_last),
    .en   (r_state == ST_IDLE),
    .gnt  (w_arb_gnt)
  );

  // State register.
  always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
    if (!SYS_RST) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next-state selection.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (|start) w_next = ST_CLEAR;
      ST_CLEAR:  w_next = ST_FEED;
      ST_FEED:   begin
        if (w_last_beat)    w_next = ST_SETTLE;
        else if (w_timeout) w_next = ST_DONE;
      end
      ST_SETTLE: w_next = ST_DONE;
      ST_DONE:   if (res_ready) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; operand path is combinational in FEED only.
  always_comb begin
    gnt       = (r_state == ST_IDLE) ? 2'b00 : r_gnt;
    in_ready  = w_feed;
    mac_a     = w_feed ? in_a : '0;
    mac_b     = w_feed ? in_b : '0;
    mac_en    = w_beat;
    mac_clr   = (r_state == ST_CLEAR);
    res_valid = (r_state == ST_DONE);
    res       = r_res;
    res_id    = r_res_id;
    res_err   = r_res_err;
  end

  // Job bookkeeping: grant/len latch, beat and stall counters, result capture.
  always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
    if (!SYS_RST) begin
      r_gnt     <= '0;
      r_idx     <= 1'b0;
      r_last    <= 1'b1;
      r_len     <= '0;
      r_cnt     <= '0;
      r_idle    <= '0;
      r_res     <= '0;
      r_res_id  <= 1'b0;
      r_res_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|start) begin
            r_gnt  <= w_arb_gnt;
            r_idx  <= w_arb_gnt[1];
            r_len  <= w_arb_gnt[1] ? len1 : len0;
            r_cnt  <= '0;
            r_idle <= '0;
          end
        end
        ST_FEED: begin
          if (w_beat) begin
            r_cnt  <= r_cnt + 1'b1;
            r_idle <= '0;
          end else if (w_timeout) begin
            r_res     <= '0;
            r_res_id  <= r_idx;
            r_res_err <= 1'b1;
          end else begin
            r_idle <= r_idle + 1'b1;
          end
        end
        ST_SETTLE: begin
          r_res     <= mac_acc;
          r_res_id  <= r_idx;
          r_res_err <= 1'b0;
        end
        ST_DONE: begin
          if (res_ready) begin
            r_last <= r_idx;
            r_gnt  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac8_dot_sched.sv
// Directed bench for mac8_dot_sched with a behavioural MAC8 accumulator.
module tb_mac8_dot_sched;

  localparam int unsigned LEN_W = 4;
  localparam int unsigned RES_W = 16 + LEN_W;

  logic             SYS_CLK = 1'b0;
  logic             SYS_RST = 1'b0;
  logic [1:0]       start = '0;
  logic [LEN_W-1:0] len0 = '0, len1 = '0;
  logic [1:0]       gnt;
  logic [7:0]       in_a = '0, in_b = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       mac_a, mac_b;
  logic             mac_en, mac_clr;
  logic [RES_W-1:0] mac_acc;
  logic [RES_W-1:0] res;
  logic             res_id, res_err, res_valid;
  logic             res_ready = 1'b0;

  int n_chk = 0;
  int n_err = 0;
  int n_clr = 0;
  int n_en  = 0;
  logic [7:0] pa[16];
  logic [7:0] pb[16];
  logic [15:0] w_prod;

  always #5 SYS_CLK = ~SYS_CLK;

  mac8_dot_sched #(.LEN_W(LEN_W), .TO_CYC(4)) dut (
    .SYS_CLK   (SYS_CLK),
    .SYS_RST   (SYS_RST),
    .start     (start),
    .len0      (len0),
    .len1      (len1),
    .gnt       (gnt),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_en    (mac_en),
    .mac_clr   (mac_clr),
    .mac_acc   (mac_acc),
    .res       (res),
    .res_id    (res_id),
    .res_err   (res_err),
    .res_valid (res_valid),
    .res_ready (res_ready)
  );

  // External MAC8 model.
  assign w_prod = 16'(mac_a) * 16'(mac_b);
  always @(posedge SYS_CLK or negedge SYS_RST) begin
    if (!SYS_RST)     mac_acc <= '0;
    else if (mac_clr) mac_acc <= '0;
    else if (mac_en)  mac_acc <= mac_acc + {4'd0, w_prod};
  end

  // Pulse counters for mac_clr / mac_en.
  always @(posedge SYS_CLK) begin
    if (mac_clr) n_clr <= n_clr + 1;
    if (mac_en)  n_en  <= n_en + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_gnt(input string tag, input logic [1:0] exp);
    int k = 0;
    while (gnt == 2'b00 && k < 20) begin
      @(negedge SYS_CLK);
      k++;
    end
    chk(tag, {30'd0, gnt}, {30'd0, exp});
  endtask

  // Entered at the negedge where the DUT is in CLEAR; leaves at DONE.
  task automatic feed(input string tag, input int n, input logic [31:0] exp_res, input logic exp_id);
    int clr0, en0;
    chk({tag, ".clr"}, {31'd0, mac_clr}, 32'd1);
    clr0 = n_clr;
    en0  = n_en;
    @(negedge SYS_CLK);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_a     = pa[i];
      in_b     = pb[i];
      #1;
      if (i == 0) chk({tag, ".mac_a"}, {24'd0, mac_a}, {24'd0, pa[0]});
      @(negedge SYS_CLK);
    end
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    chk({tag, ".settle_rdy"}, {31'd0, in_ready}, 32'd0);
    @(negedge SYS_CLK);
    chk({tag, ".valid"}, {31'd0, res_valid}, 32'd1);
    chk({tag, ".res"}, {12'd0, res}, exp_res);
    chk({tag, ".id"}, {31'd0, res_id}, {31'd0, exp_id});
    chk({tag, ".err"}, {31'd0, res_err}, 32'd0);
    chk({tag, ".nclr"}, n_clr - clr0, 32'd1);
    chk({tag, ".nen"}, n_en - en0, n);
  endtask

  task automatic ack(input string tag);
    res_ready = 1'b1;
    @(negedge SYS_CLK);
    res_ready = 1'b0;
    chk({tag, ".ack_valid"}, {31'd0, res_valid}, 32'd0);
    chk({tag, ".ack_gnt"}, {30'd0, gnt}, 32'd0);
  endtask

  task automatic set_pair(input int i, input logic [7:0] a, input logic [7:0] b);
    pa[i] = a;
    pb[i] = b;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge SYS_CLK);
    @(negedge SYS_CLK);
    chk("rst.gnt", {30'd0, gnt}, 32'd0);
    chk("rst.rdy", {31'd0, in_ready}, 32'd0);
    chk("rst.valid", {31'd0, res_valid}, 32'd0);
    chk("rst.res", {12'd0, res}, 32'd0);
    SYS_RST = 1'b1;
    @(negedge SYS_CLK);

    // Contention straight after reset: grants 0,1,0.
    len0 = 4'd0;
    len1 = 4'd1;
    start = 2'b11;
    set_pair(0, 8'd2, 8'd3);
    wait_gnt("c1.gnt", 2'b01);
    feed("c1", 1, 32'd6, 1'b0);
    ack("c1");
    set_pair(0, 8'd1, 8'd2);
    set_pair(1, 8'd3, 8'd4);
    wait_gnt("c2.gnt", 2'b10);
    feed("c2", 2, 32'd14, 1'b1);
    ack("c2");
    set_pair(0, 8'd10, 8'd10);
    wait_gnt("c3.gnt", 2'b01);
    feed("c3", 1, 32'd100, 1'b0);
    ack("c3");
    start = 2'b00;
    @(negedge SYS_CLK);

    // Single job; start dropped and len changed after the latch.
    len0 = 4'd2;
    start = 2'b01;
    set_pair(0, 8'd3, 8'd4);
    set_pair(1, 8'd5, 8'd6);
    set_pair(2, 8'd7, 8'd8);
    wait_gnt("s1.gnt", 2'b01);
    start = 2'b00;
    len0 = 4'd9;
    feed("s1", 3, 32'd98, 1'b0);
    ack("s1");

    // Full length, maximum operands.
    len0 = 4'd15;
    start = 2'b01;
    for (int i = 0; i < 16; i++) set_pair(i, 8'd255, 8'd255);
    wait_gnt("f1.gnt", 2'b01);
    feed("f1", 16, 32'd1040400, 1'b0);
    ack("f1");

    // Stall timeout after one beat.
    len0 = 4'd2;
    wait_gnt("t1.gnt", 2'b01);
    @(negedge SYS_CLK);
    in_valid = 1'b1;
    in_a = 8'd2;
    in_b = 8'd2;
    @(negedge SYS_CLK);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) chk("t1.stall_rdy", {31'd0, in_ready}, 32'd1);
      @(negedge SYS_CLK);
    end
    chk("t1.valid", {31'd0, res_valid}, 32'd1);
    chk("t1.err", {31'd0, res_err}, 32'd1);
    chk("t1.res", {12'd0, res}, 32'd0);
    ack("t1");
    len0 = 4'd1;
    set_pair(0, 8'd6, 8'd7);
    set_pair(1, 8'd1, 8'd1);
    wait_gnt("t2.gnt", 2'b01);
    feed("t2", 2, 32'd43, 1'b0);
    ack("t2");
    start = 2'b00;
    @(negedge SYS_CLK);

    // Backpressure with both requesters pending; requester 1 is due.
    len0 = 4'd0;
    len1 = 4'd0;
    start = 2'b11;
    set_pair(0, 8'd9, 8'd9);
    wait_gnt("b1.gnt", 2'b10);
    feed("b1", 1, 32'd81, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge SYS_CLK);
      if (i == 4) begin
        chk("b1.hold_res", {12'd0, res}, 32'd81);
        chk("b1.hold_gnt", {30'd0, gnt}, 32'd2);
        chk("b1.hold_valid", {31'd0, res_valid}, 32'd1);
      end
    end
    ack("b1");
    set_pair(0, 8'd2, 8'd5);
    wait_gnt("b2.gnt", 2'b01);
    feed("b2", 1, 32'd10, 1'b0);
    ack("b2");
    start = 2'b00;
    @(negedge SYS_CLK);

    // Reset in the middle of FEED.
    len0 = 4'd3;
    start = 2'b01;
    wait_gnt("r1.gnt", 2'b01);
    @(negedge SYS_CLK);
    in_valid = 1'b1;
    in_a = 8'd5;
    in_b = 8'd5;
    @(negedge SYS_CLK);
    SYS_RST = 1'b0;
    #1;
    chk("r1.gnt", {30'd0, gnt}, 32'd0);
    chk("r1.rdy", {31'd0, in_ready}, 32'd0);
    chk("r1.mac_en", {31'd0, mac_en}, 32'd0);
    chk("r1.mac_a", {24'd0, mac_a}, 32'd0);
    chk("r1.mac_clr", {31'd0, mac_clr}, 32'd0);
    chk("r1.res_valid", {31'd0, res_valid}, 32'd0);
    chk("r1.res_id", {31'd0, res_id}, 32'd0);
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    start = 2'b10;
    len1 = 4'd1;
    @(negedge SYS_CLK);
    SYS_RST = 1'b1;
    set_pair(0, 8'd4, 8'd4);
    set_pair(1, 8'd1, 8'd2);
    wait_gnt("r2.gnt", 2'b10);
    feed("r2", 2, 32'd18, 1'b1);
    ack("r2");
    start = 2'b00;
    @(negedge SYS_CLK);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mac8_dot_sched.md
MAC8_DOT_SCHED -- requirements
Module: mac8_dot_sched

Interface
REQ-001 SHALL have parameter LEN_W, default 4: width of the per-job length field; a job is 1..2^LEN_W element pairs.
REQ-002 SHALL have parameter TO_CYC, default 255: maximum number of consecutive FEED cycles without a beat before the job aborts.
REQ-003 SHALL derive RES_W = 16+LEN_W as the result/accumulator width.
REQ-004 SHALL have ports, with SYS_CLK first:
  SYS_CLK  in  1  clock; all state updates on posedge.
  SYS_RST  in  1  reset, asynchronous, active-low.
  start  in  2  per-requester job request; requester holds it high until its result is accepted.
  len0, len1  in  LEN_W each  element count minus 1 for requester 0 and 1.
  gnt  out  2  one-hot grant; only the granted requester drives the operand bus.
  in_a, in_b  in  8 each  operand pair from the granted requester.
  in_valid  in  1  operand pair valid.
  in_ready  out  1  scheduler accepts a pair.
  mac_a, mac_b  out  8 each  operands to the external MAC8 datapath.
  mac_en  out  1  MAC accumulates mac_a*mac_b at this posedge.
  mac_clr  out  1  MAC clears its accumulator at this posedge.
  mac_acc  in  RES_W  MAC accumulator value.
  res  out  RES_W  registered dot-product result.
  res_id  out  1  index of the requester that owns res.
  res_err  out  1  job aborted by timeout; res is 0.
  res_valid  out  1  result valid.
  res_ready  in  1  consumer accepts the result.

Function
REQ-005 SHALL implement the states IDLE, CLEAR, FEED, SETTLE and DONE.
REQ-006 IDLE: if start is nonzero, SHALL choose a requester round-robin; on a tie, the winner is the requester not served last (requester 0 after reset). SHALL latch its len and go to CLEAR.
REQ-007 CLEAR: SHALL assert mac_clr for exactly one cycle, assert gnt from this state until leaving DONE, and go to FEED.
REQ-008 FEED: SHALL hold in_ready=1; a beat is in_valid&&in_ready.
REQ-009 SHALL drive mac_a=in_a and mac_b=in_b combinationally, and mac_en=beat; outside FEED, mac_a, mac_b and mac_en SHALL be 0.
REQ-010 SHALL count beats; after beat number len+1, SHALL deassert in_ready in the next cycle and go to SETTLE.
REQ-011 SETTLE: SHALL register res<=mac_acc, res_id<=granted index and res_err<=0, then go to DONE.
REQ-012 SHALL restart the idle counter on each beat in FEED; when it reaches TO_CYC, SHALL go to DONE with res=0 and res_err=1.
REQ-013 DONE: SHALL hold res_valid=1 and keep res, res_id and res_err stable until res_ready.
REQ-014 On res_valid&&res_ready, SHALL clear gnt and res_valid, record the last-served requester, and go to IDLE; a new job SHALL NOT be granted in that same cycle.
REQ-015 SHALL ignore in_valid whenever the state is not FEED.
REQ-016 SHALL ignore deassertion of start while a job is granted; the job SHALL run to completion or timeout.
REQ-017 SHALL ignore len changes after the latch in IDLE.
REQ-018 Minimum latency: CLEAR, then FEED beats back-to-back, then SETTLE, then res_valid in the cycle after SETTLE.

Reset
REQ-019 While SYS_RST=0, SHALL force: state=IDLE; gnt=0, in_ready=0, mac_en=0, mac_clr=0, mac_a=0, mac_b=0; res=0, res_id=0, res_err=0, res_valid=0; counters=0; last-served=1, so requester 0 wins first.
REQ-020 Reset mid-job SHALL abandon the job without producing a result; the MAC accumulator is cleared by the next CLEAR state.

Structure
REQ-021 The state enumeration and the RES_W derivation SHALL live in shared package mac8_ctrl_pkg.
REQ-022 The round-robin choice SHALL be a sub-module rr_arb2 with inputs req[1:0], last and en, and output one-hot gnt.
REQ-023 The MAC datapath SHALL remain external; this block SHALL contain no multiplier.

Verification
REQ-024 Single job: start=01, len0=2, pairs (3,4), (5,6), (7,8) -> one mac_clr pulse, 3 mac_en pulses, res=98, res_id=0, res_valid one cycle after SETTLE.
REQ-025 Contention: start=11 after reset -> requester 0 is served first, then requester 1; with both held, grants alternate 0,1,0.
REQ-026 Full length: len=15, all pairs (255,255) -> res=1040400 with no overflow.
REQ-027 Stall and timeout: TO_CYC=4, one beat then in_valid=0 for 4 cycles -> res_err=1, res=0; the next job completes normally.
REQ-028 Backpressure and reset: res_ready=0 for 5 cycles -> res stable and no new grant; SYS_RST asserted mid-FEED -> all outputs 0, and after release start=10 gives gnt=10.
